logic_analyzer_pretrig: RTL and testbench
=========================================

# logic_analyzer_pretrig

Parametrised capture engine for on-chip debug. It records a `DATA_WIDTH`-bit monitor bus into a circular buffer of 2^`ADDR_WIDTH` samples while armed. It fires on an external trigger or a masked pattern match, and keeps a programmable number of pre-trigger samples. After capture it presents the buffer to the register-read path as a trigger-aligned logical window, so software never computes wrap offsets.

## Interface
- `DATA_WIDTH`, 256: width of the monitored bus and of each stored sample.
- `ADDR_WIDTH`, 6: buffer address width; DEPTH = 2^`ADDR_WIDTH` (64).
- `clk`  in  1  single clock for all logic; RAM is written and read on `clk`.
- `reset`  in  1  synchronous, active-high.
- `monitor_data`  in  `DATA_WIDTH`  sampled bus.
- `ext_trigger`  in  1  external trigger, level-sensitive.
- `pat_en`  in  1  enables the pattern trigger.
- `trig_mask`  in  `DATA_WIDTH`  pattern-compare mask; 1 = bit compared.
- `trig_value`  in  `DATA_WIDTH`  pattern to match.
- `pretrig_len`  in  `ADDR_WIDTH`  samples kept before the trigger; latched on arm.
- `arm`  in  1  starts a capture from IDLE or DONE.
- `abort`  in  1  returns to IDLE from any state.
- `la_read_addr`  in  `ADDR_WIDTH`  logical read index; 0 = oldest sample.
- `la_dout`  out  `DATA_WIDTH`  registered read data.
- `la_status`  out  3  000 IDLE, 001 ARMED, 010 CAPTURING, 100 DONE.
- `la_trig_src`  out  2  latched trigger source: bit0 = external, bit1 = pattern.

## Operation
- Trigger condition: `trig` = `ext_trigger` | (`pat_en` & ((`monitor_data` ^ `trig_value`) & `trig_mask`) == 0).
- `pat_en`=1 with an all-zero mask matches every cycle.
- pre_len is the latched value of `pretrig_len`.
- If `pretrig_len` ≥ DEPTH-1, pre_len = DEPTH-1 (saturates).
- With `ADDR_WIDTH` bits this caps only the all-ones value.
- IDLE:
  - Clear wr_ptr and fill_cnt.
  - On `arm`: latch pre_len and go to ARMED.
- ARMED:
  - Every cycle write `monitor_data` at wr_ptr; wr_ptr increments modulo DEPTH.
  - fill_cnt counts writes and saturates at pre_len.
  - Trigger is accepted only when `trig` is asserted and fill_cnt ≥ pre_len. fill_cnt is the value before the current write.
  - On acceptance: this cycle's sample is the trigger sample; trig_addr ← wr_ptr; `la_trig_src` ← {pattern hit, ext hit}; post_cnt ← DEPTH-1-pre_len.
  - Next state is CAPTURING, or DONE when post_cnt = 0.
  - A trigger arriving before the pre-fill completes is ignored; it is not queued.
- CAPTURING:
  - Write every cycle and decrement post_cnt.
  - Go to DONE on the cycle the last sample is written (post_cnt = 1).
  - `trig` is ignored.
- DONE:
  - No writes; the buffer is frozen.
  - On `arm`: re-arm to ARMED. Buffer contents remain readable until overwritten.
- Each capture stores exactly DEPTH samples: pre_len before the trigger, the trigger sample, and DEPTH-1-pre_len after.
- Logical read: phys = (trig_addr - pre_len + `la_read_addr`) mod DEPTH. The trigger sample sits at logical index pre_len.
- Reads are legal in any state. Outside DONE, the data at `la_read_addr` is don't-care.
- `arm` in ARMED or CAPTURING is ignored.
- `abort` has priority over `arm` and `trig`.
- `abort` leaves buffer contents undefined and clears `la_trig_src`.
- When `arm` and `trig` arrive in the same IDLE cycle, only `arm` is taken. Sampling begins the next cycle.
- pre_len = 0 gives post-trigger-only capture: the trigger sample is at index 0.

## Timing
- Reset values:
  - `la_status` = 000
  - `la_dout` = 0
  - `la_trig_src` = 0
  - wr_ptr, fill_cnt, post_cnt, trig_addr = 0
  - Buffer contents are not reset.
- `reset` mid-capture returns to IDLE on the next edge; no further writes occur.
- `arm` at edge N: `la_status` = 001 after edge N. The first sample is taken at edge N+1.
- A trigger accepted at edge T is written at T. `la_status` = 010 after T, or 100 if post_cnt = 0.
- DONE is reported after edge T + DEPTH-1-pre_len.
- Read latency is 1 cycle: `la_read_addr` presented before edge N appears on `la_dout` after edge N. This latency holds for every read.
- One sample per cycle, no backpressure. `la_status` changes only on `clk` edges.

## Test plan
- DEPTH=64, pre_len=0; ramp `monitor_data` = cycle count; `ext_trigger` pulses when the value is 100 -> DONE 63 cycles after the trigger; logical index i reads 100+i for i=0..63.
- pre_len=16; ramp data; trigger at value 200 after 500 armed cycles -> index 0 = 184, index 16 = 200, index 63 = 247; this also exercises wrap-around.
- pre_len=16; trigger 5 cycles after arm -> ignored; a second trigger at fill ≥ 16 is accepted and index 16 holds the second trigger's sample.
- Pattern trigger: mask=0xFF, value=0x5A, ext held low -> triggers on the first sample with low byte 0x5A; `la_trig_src` = 10. An all-zero mask triggers on the first eligible cycle.
- pretrig_len=63 -> DONE on the trigger cycle; index 63 = trigger sample. Then `arm` from DONE -> ARMED and a fresh capture.
- `abort` mid-CAPTURING together with `arm` -> IDLE next cycle, no writes, `la_trig_src` = 0. `reset` mid-ARMED -> all outputs return to their reset values.

Source files
------------

// File: rtl/logic_analyzer_pretrig.sv
// Pre-trigger logic analyzer capture engine.
// Records the monitor bus into a circular buffer while armed. It fires on an
// external trigger or a masked pattern match, then freezes the buffer.
// The register-read path sees a trigger-aligned logical window in which
// index 0 holds the oldest stored sample.
module logic_analyzer_pretrig #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] monitor_data,
  input  logic                  ext_trigger,
  input  logic                  pat_en,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] la_read_addr,
  output logic [DATA_WIDTH-1:0] la_dout,
  output logic [2:0]            la_status,
  output logic [1:0]            la_trig_src
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] MAX_PRE = ADDR_WIDTH'(DEPTH - 1);

  // State values double as the status encoding seen by software
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    ARMED     = 3'b001,
    CAPTURING = 3'b010,
    DONE      = 3'b100
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] pre_len;
  logic [ADDR_WIDTH-1:0] pre_len_in;
  logic [ADDR_WIDTH-1:0] post_init;
  logic [ADDR_WIDTH-1:0] rd_phys;
  logic                  pat_hit;
  logic                  trig;
  logic                  accept;
  logic                  wr_en;
  logic                  arm_take;

  // The pattern hit compares only the masked bits, so an all-zero mask always matches
  assign pat_hit    = pat_en & (((monitor_data ^ trig_value) & trig_mask) == '0);
  assign trig       = ext_trigger | pat_hit;
  // The pre-trigger length saturates at DEPTH-1 so that at least the trigger sample fits
  assign pre_len_in = (pretrig_len >= MAX_PRE) ? MAX_PRE : pretrig_len;
  assign post_init  = MAX_PRE - pre_len;
  // Logical-to-physical translation: the oldest sample sits pre_len slots before the trigger
  assign rd_phys    = trig_addr - pre_len + la_read_addr;
  assign la_status  = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode; abort overrides everything
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    accept     = 1'b0;
    arm_take   = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            arm_take   = 1'b1;
            state_next = ARMED;
          end
        end
        ARMED: begin
          wr_en = 1'b1;
          if (trig && (fill_cnt >= pre_len)) begin
            accept     = 1'b1;
            state_next = (post_init == '0) ? DONE : CAPTURING;
          end
        end
        CAPTURING: begin
          wr_en = 1'b1;
          if (post_cnt == ADDR_WIDTH'(1)) state_next = DONE;
        end
        DONE: begin
          if (arm) begin
            arm_take   = 1'b1;
            state_next = ARMED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture bookkeeping: write pointer, pre-fill count, post-trigger count and trigger record
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      trig_addr   <= '0;
      pre_len     <= '0;
      la_trig_src <= '0;
    end else begin
      if (abort) la_trig_src <= '0;
      if (arm_take) pre_len <= pre_len_in;
      if (arm_take || (state == IDLE)) begin
        wr_ptr   <= '0;
        fill_cnt <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (fill_cnt < pre_len) fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
      end
      if (accept) begin
        trig_addr   <= wr_ptr;
        la_trig_src <= {pat_hit, ext_trigger};
        post_cnt    <= post_init;
      end else if (wr_en && (state == CAPTURING)) begin
        post_cnt <= post_cnt - ADDR_WIDTH'(1);
      end
    end
  end

  // Sample buffer write port; the contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr] <= monitor_data;
  end

  // Registered read port giving one cycle of latency in every state
  always_ff @(posedge clk) begin
    if (reset) la_dout <= '0;
    else       la_dout <= mem[rd_phys];
  end

endmodule

// File: tb/tb_logic_analyzer_pretrig.sv
// Testbench for logic_analyzer_pretrig.
// It keeps a behavioural model holding the whole sample history of each capture.
// Read expectations go into a scoreboard queue, and a separate monitor checks
// la_dout one cycle after each read is issued.
module tb_logic_analyzer_pretrig;

  localparam int DW    = 256;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] monitor_data;
  logic          ext_trigger;
  logic          pat_en;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic [AW-1:0] pretrig_len;
  logic          arm;
  logic          abort;
  logic [AW-1:0] la_read_addr;
  logic [DW-1:0] la_dout;
  logic [2:0]    la_status;
  logic [1:0]    la_trig_src;

  int            tests = 0;
  int            fails = 0;
  bit            rd_req = 1'b0;
  logic [DW-1:0] exp_q[$];
  string         name_q[$];

  logic_analyzer_pretrig #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .monitor_data(monitor_data), .ext_trigger(ext_trigger),
    .pat_en(pat_en), .trig_mask(trig_mask), .trig_value(trig_value),
    .pretrig_len(pretrig_len), .arm(arm), .abort(abort), .la_read_addr(la_read_addr),
    .la_dout(la_dout), .la_status(la_status), .la_trig_src(la_trig_src)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Runaway guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each issued read is compared one cycle later
  always @(posedge clk) begin
    if (rd_req) begin
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL scoreboard: read with no expected entry, got %0h expected none", la_dout);
      end else begin
        checkOutput(name_q.pop_front(), la_dout, exp_q.pop_front());
      end
    end
  end

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete capture: arm, stream samples, model the trigger rules, then read the window
  task automatic applyStimulus(input string tag, input int pre, input bit use_ramp, input int ramp_base,
                               input int ext_n1, input int ext_n2, input int ext_pct, input bit pat,
                               input logic [DW-1:0] mask, input logic [DW-1:0] value, input bit force5a,
                               input int arm_n, input int abort_n, input bit arm_with_trig);
    logic [DW-1:0] hist[$];
    logic [DW-1:0] d;
    logic [7:0]    b;
    logic [1:0]    src;
    int            k, last, tmp;
    bit            trig_seen, done, e, ph;
    k = 0; last = 0; src = 2'b00; trig_seen = 1'b0; done = 1'b0;
    @(negedge clk);
    pretrig_len  = AW'(pre);
    arm          = 1'b1;
    ext_trigger  = arm_with_trig;
    pat_en       = 1'b0;
    monitor_data = rand_word();
    @(negedge clk);
    arm         = 1'b0;
    ext_trigger = 1'b0;
    checkOutput($sformatf("%s status after arm", tag), la_status, 3'b001);
    for (int n = 0; n < 3000 && !done; n++) begin
      if (use_ramp) begin
        tmp = ramp_base + n;
        d   = {{(DW-32){tmp[31]}}, tmp};
      end else begin
        d = rand_word();
      end
      if (force5a) begin
        b = 8'($urandom);
        if (b == 8'h5A) b = 8'h00;
        d[7:0] = ($urandom_range(0, 5) == 0) ? 8'h5A : b;
      end
      if (trig_seen && abort_n > 0 && n == k + abort_n) begin
        monitor_data = d;
        abort = 1'b1;
        arm   = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        arm   = 1'b0;
        checkOutput($sformatf("%s status after abort", tag), la_status, 3'b000);
        checkOutput($sformatf("%s trig_src after abort", tag), la_trig_src, 2'b00);
        return;
      end
      e  = (n == ext_n1) || (n == ext_n2) || ($urandom_range(0, 99) < ext_pct);
      ph = pat && (((d ^ value) & mask) == '0);
      monitor_data = d;
      ext_trigger  = e;
      pat_en       = pat;
      trig_mask    = mask;
      trig_value   = value;
      arm          = (n == arm_n);
      if (!trig_seen && (e || ph) && n >= pre) begin
        trig_seen = 1'b1;
        k         = n;
        src       = {ph, e};
        last      = k + DEPTH - 1 - pre;
      end
      hist.push_back(d);
      @(negedge clk);
      arm = 1'b0;
      if (trig_seen && n == last) begin
        checkOutput($sformatf("%s status at done", tag), la_status, 3'b100);
        done = 1'b1;
      end else begin
        checkOutput($sformatf("%s status n=%0d", tag, n), la_status, trig_seen ? 3'b010 : 3'b001);
      end
    end
    ext_trigger = 1'b0;
    pat_en      = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: status %0b, never reached 100", tag, la_status);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      return;
    end
    checkOutput($sformatf("%s trig_src", tag), la_trig_src, src);
    // Buffer must stay frozen in DONE even with triggers and new data present
    for (int i = 0; i < 3; i++) begin
      monitor_data = rand_word();
      ext_trigger  = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("%s status frozen", tag), la_status, 3'b100);
    end
    ext_trigger = 1'b0;
    for (int i = 0; i < DEPTH + 16; i++) begin
      int idx;
      idx = (i < DEPTH) ? i : $urandom_range(0, DEPTH - 1);
      la_read_addr = AW'(idx);
      rd_req       = 1'b1;
      exp_q.push_back(hist[k - pre + idx]);
      name_q.push_back($sformatf("%s read idx %0d", tag, idx));
      @(negedge clk);
    end
    rd_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] m;
    reset = 1'b1; monitor_data = '0; ext_trigger = 1'b0; pat_en = 1'b0;
    trig_mask = '0; trig_value = '0; pretrig_len = '0; arm = 1'b0; abort = 1'b0;
    la_read_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset status", la_status, 3'b000);
    checkOutput("reset dout", la_dout, '0);
    checkOutput("reset trig_src", la_trig_src, 2'b00);

    // Post-trigger-only ramp capture, trigger offered together with arm
    applyStimulus("t1_pre0", 0, 1'b1, 0, 100, -1, 0, 1'b0, '0, '0, 1'b0, -1, -1, 1'b1);
    // Long armed period with wrap-around before the trigger
    applyStimulus("t2_pre16", 16, 1'b1, -300, 500, -1, 0, 1'b0, '0, '0, 1'b0, -1, -1, 1'b0);
    // Early trigger ignored, arm while armed ignored, later trigger accepted
    applyStimulus("t3_early", 16, 1'b1, 1000, 5, 40, 0, 1'b0, '0, '0, 1'b0, 10, -1, 1'b0);
    // Pattern trigger on low byte 0x5A
    applyStimulus("t4_pat", int'($urandom_range(0, 20)), 1'b0, 0, -1, -1, 0, 1'b1,
                  256'hFF, 256'h5A, 1'b1, -1, -1, 1'b0);
    // All-zero mask matches on the first eligible cycle
    applyStimulus("t4_mask0", 7, 1'b0, 0, -1, -1, 0, 1'b1, '0, rand_word(), 1'b0, -1, -1, 1'b0);
    // Maximum pre-trigger length: done on the trigger cycle, then re-arm from DONE
    applyStimulus("t5_pre63", 63, 1'b0, 0, 70, -1, 0, 1'b0, '0, '0, 1'b0, -1, -1, 1'b0);
    applyStimulus("t5_rearm", int'($urandom_range(0, 63)), 1'b0, 0, -1, -1, 3, 1'b0, '0, '0, 1'b0, -1, -1, 1'b0);
    // Abort together with arm during CAPTURING
    applyStimulus("t6_abort", 10, 1'b0, 0, 12, -1, 0, 1'b0, '0, '0, 1'b0, -1, 8, 1'b0);

    // Randomized captures mixing external and sparse pattern triggers
    for (int r = 0; r < 5; r++) begin
      m = '0;
      m[$urandom_range(0, 7)] = 1'b1;
      m[$urandom_range(0, 7)] = 1'b1;
      m[$urandom_range(0, 7)] = 1'b1;
      applyStimulus($sformatf("rnd%0d", r), int'($urandom_range(0, 63)), 1'b0, 0, -1, -1,
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), m, rand_word(),
                    1'b0, -1, -1, 1'($urandom_range(0, 1)));
    end

    // Reset while armed returns every output to its reset value
    @(negedge clk);
    pretrig_len = AW'(5);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (3) begin
      monitor_data = rand_word();
      @(negedge clk);
    end
    checkOutput("t7 status before reset", la_status, 3'b001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t7 reset status", la_status, 3'b000);
    checkOutput("t7 reset dout", la_dout, '0);
    checkOutput("t7 reset trig_src", la_trig_src, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
